data_mem: RTL and testbench

Word-addressed, byte-write-enabled data memory for the SimpleRV core's load/store path. Holds 2^AWIDTH words of DWIDTH bits, with a combinational read port and a synchronous, per-byte-masked write port. Sits between the core's memory stage and its load/store alignment logic. Sub-word alignment and sign extension happen upstream and downstream, not here.

---
 rtl/data_mem.sv | 35 +++
 tb/tb_data_mem.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Word-addressed data memory with a combinational read port and a synchronous,
// byte-masked write port for the SimpleRV load/store path.
module data_mem #(
  parameter int DWIDTH = 32,  // must be a multiple of 8
  parameter int AWIDTH = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DWIDTH/8-1:0] wbe,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   din,
  output logic [DWIDTH-1:0]   dout
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int DEPTH  = 1 << AWIDTH;

  // NOTE: the array is never reset, so it maps onto RAM; contents are zero
  // only at power-up and survive rst_n pulses.
  logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};

  // rst_n only gates writes here; there is no flop for it to clear.
  always_ff @(posedge clk) begin
    if (rst_n && en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wbe[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // Reset forces the read port to zero without disturbing the contents.
  assign dout = rst_n ? mem[addr] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_data_mem;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NB-1:0] wbe;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [1 << AW];

  data_mem #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .wbe  (wbe),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  // Expected word after a masked write: enabled bytes come from new, the rest from old.
  function automatic logic [DW-1:0] merged(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [NB-1:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < NB; i++) if (be[i]) mask = mask | (DW'(8'hff) << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Drive a write cycle on the falling edge, let one rising edge capture it,
  // then settle 1 ns past the edge.
  task automatic do_write(input logic e, input logic [NB-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    en = e; wbe = be; addr = a; din = d;
    @(posedge clk);
    if (rst_n && e) ref_mem[a] = merged(ref_mem[a], d, be);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (dut.mem[0] !== 32'h0) begin
      errors++; $display("FAIL powerup_mem0: got %h expected %h", dut.mem[0], 32'h0);
    end
    checks++;
    if (dout !== 32'h0) begin
      errors++; $display("FAIL powerup_dout: got %h expected %h", dout, 32'h0);
    end
  endtask

  task automatic test_full_word;
    do_write(1'b1, 4'b1111, 10'd0, 32'hdeadbeef);
    checks++;
    if (dut.mem[0] !== 32'hdeadbeef) begin
      errors++; $display("FAIL full_word_mem: got %h expected %h", dut.mem[0], 32'hdeadbeef);
    end
    checks++;
    if (dout !== 32'hdeadbeef) begin
      errors++; $display("FAIL full_word_dout: got %h expected %h", dout, 32'hdeadbeef);
    end
  endtask

  task automatic test_byte_writes;
    do_write(1'b1, 4'b0001, 10'd1, 32'hcafebabe);
    checks++;
    if (dut.mem[1] !== 32'h000000be) begin
      errors++; $display("FAIL byte_write_b0: got %h expected %h", dut.mem[1], 32'h000000be);
    end
    do_write(1'b1, 4'b0011, 10'd1, 32'hffffffff);
    checks++;
    if (dut.mem[1] !== 32'h0000ffff) begin
      errors++; $display("FAIL byte_write_b01: got %h expected %h", dut.mem[1], 32'h0000ffff);
    end
    // Upper bytes alone, leaving the low half in place.
    do_write(1'b1, 4'b1000, 10'd2, 32'h5a000000);
    do_write(1'b1, 4'b0100, 10'd2, 32'h00a50000);
    checks++;
    if (dut.mem[2] !== 32'h5aa50000) begin
      errors++; $display("FAIL byte_write_hi: got %h expected %h", dut.mem[2], 32'h5aa50000);
    end
    // wbe=0 with en=1 is not a write.
    do_write(1'b1, 4'b0000, 10'd2, 32'h11111111);
    checks++;
    if (dut.mem[2] !== 32'h5aa50000) begin
      errors++; $display("FAIL zero_wbe: got %h expected %h", dut.mem[2], 32'h5aa50000);
    end
  endtask

  task automatic test_async_read;
    @(negedge clk);
    en = 1'b1; wbe = 4'b0000; addr = 10'd0;
    #1;
    checks++;
    if (dout !== 32'hdeadbeef) begin
      errors++; $display("FAIL async_read_a0: got %h expected %h", dout, 32'hdeadbeef);
    end
    addr = 10'd1;
    #0.1;
    checks++;
    if (dout !== 32'h0000ffff) begin
      errors++; $display("FAIL async_read_a1: got %h expected %h", dout, 32'h0000ffff);
    end
  endtask

  task automatic test_enable_gating;
    do_write(1'b0, 4'b1111, 10'd0, 32'h00000000);
    checks++;
    if (dut.mem[0] !== 32'hdeadbeef) begin
      errors++; $display("FAIL enable_gating: got %h expected %h", dut.mem[0], 32'hdeadbeef);
    end
  endtask

  task automatic test_reset_pulse;
    @(negedge clk);
    en = 1'b1; wbe = 4'b1111; din = 32'h12345678; addr = 10'd0;
    #1;
    rst_n = 1'b0;
    #0.1;
    checks++;
    if (dout !== 32'h0) begin
      errors++; $display("FAIL reset_dout: got %h expected %h", dout, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.mem[0] !== 32'hdeadbeef) begin
      errors++; $display("FAIL reset_no_write: got %h expected %h", dut.mem[0], 32'hdeadbeef);
    end
    checks++;
    if (dout !== 32'h0) begin
      errors++; $display("FAIL reset_dout_held: got %h expected %h", dout, 32'h0);
    end
    en = 1'b0;
    rst_n = 1'b1;
    #0.1;
    checks++;
    if (dout !== 32'hdeadbeef) begin
      errors++; $display("FAIL reset_release: got %h expected %h", dout, 32'hdeadbeef);
    end
  endtask

  // Random traffic over a small address window (for reuse) plus occasional
  // far addresses; checks old word before the edge and merged word after it.
  task automatic test_random;
    logic          e;
    logic [NB-1:0] be;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int n = 0; n < 300; n++) begin
      e  = ($urandom_range(0, 3) != 0);
      be = NB'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      d  = $urandom;
      @(negedge clk);
      en = e; wbe = be; addr = a; din = d;
      #1;
      checks++;
      if (dout !== ref_mem[a]) begin
        errors++; $display("FAIL rand_pre_edge[%0d] addr %0d: got %h expected %h", n, a, dout, ref_mem[a]);
      end
      @(posedge clk);
      if (e) ref_mem[a] = merged(ref_mem[a], d, be);
      #1;
      checks++;
      if (dout !== ref_mem[a]) begin
        errors++; $display("FAIL rand_post_edge[%0d] addr %0d: got %h expected %h", n, a, dout, ref_mem[a]);
      end
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (dut.mem[k] !== ref_mem[k]) begin
        errors++; $display("FAIL rand_sweep mem[%0d]: got %h expected %h", k, dut.mem[k], ref_mem[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    rst_n = 1'b1; en = 1'b1; wbe = '0; addr = '0; din = '0;
    test_reset;
    test_full_word;
    test_byte_writes;
    test_async_read;
    test_enable_gating;
    test_reset_pulse;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
